// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the architectural PC and sequences
// instruction fetch, commit, halt and misalignment fault.
module pc_fetch_sequencer #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 32
) (
  input  logic               CLK,
  input  logic               Reset_L,
  input  logic [ADDR_W-1:0]  startPC,
  input  logic [ADDR_W-1:0]  NextPC,
  input  logic               stall,
  input  logic               halt,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [ADDR_W-1:0]  CurrentPC,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               halted,
  output logic               fault,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [2:0] {
    S_INIT,
    S_FETCH,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_t;

  state_t state;
  state_t state_nx;

  logic commit;
  logic misalign;

  assign commit    = (state == S_EXEC) && !stall;
  assign misalign  = |NextPC[1:0];
  assign imem_addr = CurrentPC;

  // state register
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) state <= S_INIT;
    else          state <= state_nx;
  end

  // next-state: fault wins over halt on a commit
  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:  state_nx = S_FETCH;
      S_FETCH: if (imem_ack) state_nx = S_EXEC;
      S_EXEC: begin
        if (commit) begin
          if (misalign)  state_nx = S_FAULT;
          else if (halt) state_nx = S_HALT;
          else           state_nx = S_FETCH;
        end
      end
      S_HALT:  state_nx = S_HALT;
      S_FAULT: state_nx = S_FAULT;
      default: state_nx = S_INIT;
    endcase
  end

  // status outputs decoded from state only
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    fault       = 1'b0;
    unique case (1'b1)
      (state == S_FETCH): imem_req    = 1'b1;
      (state == S_EXEC):  instr_valid = 1'b1;
      (state == S_HALT):  halted      = 1'b1;
      (state == S_FAULT): fault       = 1'b1;
      default: ;
    endcase
  end

  // PC, instruction latch and retire counter
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      CurrentPC <= '0;
      instr     <= '0;
      retired   <= '0;
    end else begin
      if (state == S_INIT) begin
        CurrentPC <= startPC;
      end
      if ((state == S_FETCH) && imem_ack) begin
        instr <= imem_data;
      end
      if (commit && !misalign) begin
        CurrentPC <= NextPC;
        retired   <= retired + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: scoreboard bench with an instruction-level
// reference model of PC, retire count and terminal conditions.
module tb_pc_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        Reset_L = 1'b0;
  logic [63:0] startPC = '0;
  logic [63:0] NextPC = '0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic [63:0] CurrentPC;
  logic [31:0] instr;
  logic        instr_valid;
  logic        halted;
  logic        fault;
  logic [31:0] retired;

  pc_fetch_sequencer dut (
    .CLK(CLK),
    .Reset_L(Reset_L),
    .startPC(startPC),
    .NextPC(NextPC),
    .stall(stall),
    .halt(halt),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_data(imem_data),
    .CurrentPC(CurrentPC),
    .instr(instr),
    .instr_valid(instr_valid),
    .halted(halted),
    .fault(fault),
    .retired(retired)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
    logic [31:0] ret;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  logic [63:0] m_pc;
  logic [31:0] m_ret;
  logic [31:0] held;
  logic        prev_iv = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // monitor: each new instr_valid pops one expected fetch
  always @(negedge CLK) begin
    exp_t e;
    if (!Reset_L) begin
      prev_iv = 1'b0;
    end else begin
      if (instr_valid && !prev_iv) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("instr", instr, e.data);
          chk("pc_at_exec", CurrentPC, e.pc);
          chk("addr_at_exec", imem_addr, e.pc);
          chk("retired_at_exec", retired, e.ret);
          held = e.data;
        end
      end else if (instr_valid && prev_iv) begin
        chk("instr_hold", instr, held);
      end
      prev_iv = instr_valid;
    end
  end

  task automatic do_reset(input logic [63:0] spc);
    Reset_L = 1'b0;
    stall = 1'b0;
    halt = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_iv", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_pc", CurrentPC, 0);
    chk("rst_instr", instr, 0);
    chk("rst_retired", retired, 0);
    exp_q.delete();
    startPC = spc;
    @(negedge CLK);
    Reset_L = 1'b1;
    m_pc = spc;
    m_ret = 0;
  endtask

  task automatic do_fetch(input int dly, input logic [31:0] d);
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("req_wait", imem_req, 1);
    if (!imem_req) return;
    chk("fetch_addr", imem_addr, m_pc);
    for (int i = 0; i < dly; i++) begin
      imem_ack = 1'b0;
      @(negedge CLK);
      chk("req_held", imem_req, 1);
      chk("addr_stable", imem_addr, m_pc);
      chk("iv_low_wait", instr_valid, 0);
    end
    imem_ack = 1'b1;
    imem_data = d;
    exp_q.push_back('{m_pc, d, m_ret});
    @(negedge CLK);
    imem_ack = 1'b0;
    imem_data = $urandom;
  endtask

  task automatic do_exec(input logic [63:0] npc, input int nst,
                         input logic h, output logic term);
    for (int i = 0; i < nst; i++) begin
      stall = 1'b1;
      NextPC = (i % 2 == 0) ? 64'h80 : 64'h90;
      if ($urandom_range(0, 1) == 1) NextPC = {$urandom, $urandom};
      halt = 1'($urandom_range(0, 1));
      imem_ack = 1'($urandom_range(0, 1));
      imem_data = $urandom;
      @(negedge CLK);
      chk("stall_pc", CurrentPC, m_pc);
      chk("stall_ret", retired, m_ret);
      chk("stall_iv", instr_valid, 1);
    end
    stall = 1'b0;
    imem_ack = 1'b0;
    NextPC = npc;
    halt = h;
    @(negedge CLK);
    halt = 1'b0;
    NextPC = {$urandom, $urandom};
    if (npc[1:0] != 2'b00) begin
      term = 1'b1;
      chk("fault_set", fault, 1);
      chk("fault_halted", halted, 0);
      chk("fault_pc", CurrentPC, m_pc);
      chk("fault_ret", retired, m_ret);
      chk("fault_iv", instr_valid, 0);
    end else begin
      m_pc = npc;
      m_ret = m_ret + 1;
      term = h;
      chk("commit_pc", CurrentPC, m_pc);
      chk("commit_ret", retired, m_ret);
      chk("commit_iv", instr_valid, 0);
      if (h) chk("halt_set", halted, 1);
      else chk("refetch_req", imem_req, 1);
    end
    if (term) begin
      for (int i = 0; i < 3; i++) begin
        imem_ack = 1'($urandom_range(0, 1));
        @(negedge CLK);
        chk("term_req", imem_req, 0);
        chk("term_iv", instr_valid, 0);
        chk("term_pc", CurrentPC, m_pc);
        chk("term_flag", {62'd0, halted, fault},
            {62'd0, (npc[1:0] == 2'b00), (npc[1:0] != 2'b00)});
      end
      imem_ack = 1'b0;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic t;
    logic [63:0] npc;
    int r;
    int n;
    #2;
    do_reset(64'h40);
    do_fetch(0, 32'hF84003E9);
    do_exec(64'h44, 0, 1'b0, t);
    do_fetch(5, $urandom);
    do_exec(64'h90, 3, 1'b0, t);
    do_fetch(1, $urandom);
    do_exec(64'h46, 0, 1'b0, t);

    do_reset(64'h100);
    do_fetch(2, $urandom);
    do_exec(64'h104, 1, 1'b1, t);

    do_reset(64'h200);
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("midfetch_req", imem_req, 1);
    #3;
    do_reset(64'h300);
    do_fetch(0, $urandom);
    do_exec(64'h304, 0, 1'b0, t);

    do_reset(64'hFFFF_FFFF_FFFF_FFFC);
    do_fetch(0, $urandom);
    do_exec(64'h0, 0, 1'b0, t);
    do_fetch(0, $urandom);
    do_exec(64'h47, 0, 1'b1, t);

    for (int ep = 0; ep < 40; ep++) begin
      do_reset({$urandom, $urandom} & ~64'h3);
      for (int k = 0; k < 30; k++) begin
        do_fetch($urandom_range(0, 4), $urandom);
        r = $urandom_range(0, 19);
        npc = {$urandom, $urandom} & ~64'h3;
        if (r == 0) npc[1:0] = 2'($urandom_range(1, 3));
        do_exec(npc, $urandom_range(0, 3), (r == 1 || r == 0), t);
        if (t) break;
      end
    end

    @(negedge CLK);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Owns the architectural PC register and sequences instruction fetch for the LEGv8 datapath.
- Issues a request/acknowledge fetch to instruction memory and presents the fetched instruction to decode.
- Commits the next-PC value computed by the branch/next-PC logic once the current instruction completes.
- Adds start-PC load, stall, halt, a misalignment fault and a retired-instruction counter.

Parameters:
ADDR_W, 64, PC and instruction-address width
INSTR_W, 32, instruction word width
CNT_W, 32, retired-instruction counter width

Ports:
CLK  input  1  system clock; all state updates on rising edge
Reset_L  input  1  asynchronous active-low reset
startPC  input  ADDR_W  PC loaded after reset is released
NextPC  input  ADDR_W  next PC from the next-PC logic; sampled at commit
stall  input  1  hold the current instruction in EXEC; no commit
halt  input  1  stop after the current instruction commits
imem_req  output  1  fetch request to instruction memory
imem_addr  output  ADDR_W  fetch address; always equals CurrentPC
imem_ack  input  1  memory returns imem_data this cycle
imem_data  input  INSTR_W  fetched instruction word
CurrentPC  output  ADDR_W  architectural PC
instr  output  INSTR_W  latched instruction for decode
instr_valid  output  1  instr is valid and awaiting commit
halted  output  1  sequencer stopped by halt
fault  output  1  misaligned NextPC detected
retired  output  CNT_W  count of committed instructions

Behaviour:
- Reset (Reset_L=0, asynchronous):
  - state=INIT; CurrentPC=0, instr=0, retired=0.
  - imem_req, instr_valid, halted and fault are all 0.
  - All outputs drop immediately, including mid-fetch; any ack in flight is discarded.
- States: INIT, FETCH, EXEC, HALT, FAULT. All outputs are registered or decoded from state only (no input-to-output combinational path except imem_addr=CurrentPC).
- INIT:
  - First edge with Reset_L=1: CurrentPC<=startPC; go to FETCH.
- FETCH:
  - imem_req=1; hold it until imem_ack=1.
  - On an ack edge: instr<=imem_data, instr_valid<=1, go to EXEC.
  - Minimum fetch latency is 1 cycle (ack in the first FETCH cycle).
  - There is no timeout; FETCH waits indefinitely.
- EXEC:
  - imem_req=0 and instr_valid=1.
  - If stall=1: hold state; CurrentPC, instr and retired are unchanged. halt is ignored while stall=1.
  - If stall=0 the instruction commits:
    - If NextPC[1:0]!=0: go to FAULT, fault<=1, CurrentPC unchanged, retired unchanged, instr_valid<=0.
    - Otherwise: CurrentPC<=NextPC, retired<=retired+1 (wraps modulo 2^CNT_W), instr_valid<=0.
    - Next state is HALT (halted<=1) if halt=1, else FETCH.
- HALT and FAULT:
  - Terminal states; only reset exits them.
  - imem_req=0 and instr_valid=0.
  - halted or fault respectively stays at 1.
- Edge cases:
  - imem_ack outside FETCH is ignored.
  - A commit and a misaligned NextPC in the same cycle give FAULT (fault takes precedence over halt).
  - PC arithmetic is not performed here. NextPC wrap-around (e.g. 0xFFFF_FFFF_FFFF_FFFC + 4 = 0) is accepted as delivered.
  - startPC is not alignment-checked.

Test Plan:
- Reset then release with startPC=0x40 and ack on the first FETCH cycle → CurrentPC=0x40, imem_addr=0x40; instr_valid=1 one cycle after ack; instr=0xF84003E9.
- Commit with NextPC=0x44 and stall=0 → CurrentPC=0x44, retired=1, re-enters FETCH with imem_req=1 on the next cycle.
- Ack delayed 5 cycles → imem_req held high 5 cycles with imem_addr stable; instr_valid stays 0 until the ack edge.
- stall=1 for 3 EXEC cycles while NextPC changes between 0x80 and 0x90 → CurrentPC and retired frozen; on release commits NextPC=0x90.
- NextPC=0x46 at commit → fault=1, CurrentPC unchanged, imem_req stays 0 thereafter. Separately, halt=1 at commit → halted=1, retired incremented, no further fetch.
- Reset_L asserted mid-FETCH → imem_req=0 immediately; after release CurrentPC reloads startPC and retired=0.
